// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: the fetched {pc, raw} pair and pc arithmetic.
package fetch_queue_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] gpreg;

    localparam gpreg INSTR_BYTES = gpreg'(4);

    typedef struct packed {
        gpreg        pc;
        logic [31:0] raw;
    } fetched_t;

    // Sequential successor; wraps naturally mod 2^32.
    function automatic gpreg next_pc(input gpreg pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_queue_fifo_ram.sv
// Storage array for fetch_queue: one synchronous write port, one combinational read port.
module fifo_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO that drops wrong-path responses by pc check.
// Optional FETCH_QUEUE_BYPASS_EN: empty-queue enqueues appear on decoded in the same cycle.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int   DEPTH    = 4,
    parameter gpreg RESET_PC = 32'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetched_valid,
    output logic                       fetched_ready,
    input  fetched_t                   fetched_data,
    output logic                       decoded_valid,
    input  logic                       decoded_ready,
    output fetched_t                   decoded_data,
    input  logic                       flush,
    input  gpreg                       flush_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    gpreg          exp_pc_q, exp_pc_d;

    logic     stale;
    logic     full;
    logic     empty;
    logic     enq;
    logic     deq;
    logic     pop;
    logic     wr_en;
    fetched_t ram_rd_data;
`ifdef FETCH_QUEUE_BYPASS_EN
    logic     bypass;
`endif

    fifo_ram #(
        .WIDTH ($bits(fetched_t)),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (fetched_data),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    always_comb begin
        stale         = fetched_valid && (fetched_data.pc != exp_pc_q);
        full          = (count_q == CW'(DEPTH));
        empty         = (count_q == '0);
        // Deliberately independent of decoded_ready: a full queue stalls even if decode pops.
        fetched_ready = flush || stale || !full;
        enq           = fetched_valid && fetched_ready && !flush && !stale;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass        = empty && enq;
        decoded_valid = (!empty && !flush) || bypass;
        decoded_data  = empty ? fetched_data : ram_rd_data;
        deq           = decoded_valid && decoded_ready;
        wr_en         = enq && !(bypass && decoded_ready);
`else
        decoded_valid = !empty && !flush;
        decoded_data  = ram_rd_data;
        deq           = decoded_valid && decoded_ready;
        wr_en         = enq;
`endif
        pop = deq && !empty;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        exp_pc_d = exp_pc_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            exp_pc_d = flush_pc;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (enq) begin
                exp_pc_d = next_pc(exp_pc_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            exp_pc_q <= RESET_PC;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            exp_pc_q <= exp_pc_d;
        end
    end

    assign occupancy = count_q;

endmodule
